// File: rtl/spi_slave_pkg.sv
// Shared types and defaults for the SPI slave register command sequencer.
package spi_slave_pkg;

    localparam int         ADDR_W_DEF      = 7;
    localparam int         CMD_RD_BIT      = 7;
    localparam logic [7:0] STATUS_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WR_DATA,
        ST_RD_FETCH,
        ST_RD_WAIT,
        ST_RD_DATA,
        ST_DRAIN
    } state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/spi_addr_ctr.sv
// Loadable register-bus address counter; increments wrap modulo 2^ADDR_W.
module spi_addr_ctr #(
    parameter int ADDR_W = 7
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_val_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] addr_o
);

    localparam logic [ADDR_W-1:0] ONE = 1;

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    always_comb begin
        addr_d = addr_q;
        if (load_i) begin
            addr_d = load_val_i;
        end else if (inc_i) begin
            addr_d = addr_q + ONE;
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr_o = addr_q;

endmodule

// File: rtl/spi_slave_reg_ctrl.sv
// Turns each CS_N frame of SPI bytes into register-bus write/read bursts and
// supplies the next MISO byte plus frame/overrun status.
module spi_slave_reg_ctrl
    import spi_slave_pkg::*;
#(
    parameter int         ADDR_W      = ADDR_W_DEF,
    parameter int         RD_LAT      = 1,
    parameter logic [7:0] STATUS_BYTE = STATUS_BYTE_DEF
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              frame_end,
    input  logic [7:0]        rx_byte,
    input  logic              rx_valid,
    output logic [7:0]        tx_byte,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [7:0]        bus_wdata,
    output logic              bus_we,
    output logic              bus_re,
    input  logic [7:0]        bus_rdata,
    output logic              busy,
    output logic              ovr_err,
    output logic [7:0]        byte_cnt
);

    localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

    state_e     state_q,    state_d;
    logic [7:0] tx_byte_q,  tx_byte_d;
    logic [7:0] wdata_q,    wdata_d;
    logic       we_q,       we_d;
    logic       re_q,       re_d;
    logic       busy_q,     busy_d;
    logic       ovr_err_q,  ovr_err_d;
    logic [7:0] byte_cnt_q, byte_cnt_d;
    logic [1:0] lat_cnt_q,  lat_cnt_d;
    logic       addr_load;
    logic       addr_inc;

    spi_addr_ctr #(
        .ADDR_W(ADDR_W)
    ) u_addr_ctr (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .load_i    (addr_load),
        .load_val_i(rx_byte[ADDR_W-1:0]),
        .inc_i     (addr_inc),
        .addr_o    (bus_addr)
    );

    always_comb begin
        state_d    = state_q;
        tx_byte_d  = tx_byte_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        busy_d     = busy_q;
        ovr_err_d  = ovr_err_q;
        byte_cnt_d = byte_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        addr_load  = 1'b0;
        // The address advances in the cycle after each write strobe.
        addr_inc   = we_q;

        if (busy_q && rx_valid) begin
            byte_cnt_d = sat_inc8(byte_cnt_q);
        end

        case (state_q)
            ST_IDLE: ;
            ST_CMD: begin
                if (rx_valid) begin
                    addr_load = 1'b1;
                    state_d   = rx_byte[CMD_RD_BIT] ? ST_RD_FETCH : ST_WR_DATA;
                end
            end
            ST_WR_DATA: begin
                if (rx_valid) begin
                    wdata_d = rx_byte;
                    we_d    = 1'b1;
                end
            end
            ST_RD_FETCH: begin
                lat_cnt_d = '0;
                if (rx_valid) begin
                    ovr_err_d = 1'b1;
                    state_d   = ST_DRAIN;
                end else begin
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (rx_valid) begin
                    ovr_err_d = 1'b1;
                    state_d   = ST_DRAIN;
                end else if (lat_cnt_q == LAT_LAST) begin
                    tx_byte_d = bus_rdata;
                    addr_inc  = 1'b1;
                    lat_cnt_d = '0;
                    state_d   = ST_RD_DATA;
                end else begin
                    lat_cnt_d = lat_cnt_q + 2'd1;
                end
            end
            ST_RD_DATA: begin
                if (rx_valid) begin
                    state_d = ST_RD_FETCH;
                end
            end
            ST_DRAIN: ;
            default: state_d = ST_IDLE;
        endcase

        // A coincident byte has been handled above; the frame still closes.
        if (frame_end && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            busy_d    = 1'b0;
            tx_byte_d = tx_byte_q;
            addr_inc  = we_q;
        end

        // A new frame overrides everything; a missed frame_end marks an abort.
        if (frame_start) begin
            state_d    = ST_CMD;
            tx_byte_d  = STATUS_BYTE;
            busy_d     = 1'b1;
            byte_cnt_d = '0;
            ovr_err_d  = (state_q != ST_IDLE);
            lat_cnt_d  = '0;
            we_d       = 1'b0;
            addr_load  = 1'b0;
            addr_inc   = we_q;
        end

        re_d = (state_d == ST_RD_FETCH);
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tx_byte_q  <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            busy_q     <= 1'b0;
            ovr_err_q  <= 1'b0;
            byte_cnt_q <= '0;
            lat_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            tx_byte_q  <= tx_byte_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            re_q       <= re_d;
            busy_q     <= busy_d;
            ovr_err_q  <= ovr_err_d;
            byte_cnt_q <= byte_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
        end
    end

    assign tx_byte   = tx_byte_q;
    assign bus_wdata = wdata_q;
    assign bus_we    = we_q;
    assign bus_re    = re_q;
    assign busy      = busy_q;
    assign ovr_err   = ovr_err_q;
    assign byte_cnt  = byte_cnt_q;

endmodule
